dmem_responder: RTL
===================

# dmem_responder

Data-memory responder on the far end of the core's MemRead/MemWrite control interface. It accepts one load or store request from the execute/memory stage and services it against an internal word array with a fixed, parameterised number of wait states. While the access is outstanding it drives `stall` to freeze the pipeline. It returns load data with a one-cycle `rvalid` strobe. It sits between the datapath's ALU result and the register-file write-back mux.

## Interface
Parameters:
- ADDR_W, 9, byte-address width; the array holds 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2, number of stall cycles per access; legal range is 1 to 15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from the controller.
- MemWrite  in  1  store request from the controller.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  32  store data (register Read data 2).
- rdata  out  32  load data, registered.
- rvalid  out  1  one-cycle strobe marking the load-completion cycle.
- stall  out  1  pipeline freeze request.
- err  out  1  misaligned-access strobe; present only under the configuration macro, otherwise tied to 0.

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- The block has three states: IDLE, WAIT and DONE. It holds a 4-bit wait counter `cnt`.
- A request is present when `req = MemRead | MemWrite`.
  - If both strobes are high, it is treated as a store; the read is ignored.
- **IDLE**
  - When `req` is high, latch op, `addr[ADDR_W-1:2]` and `wdata`, then load `cnt = WAIT_CYCLES-1`.
  - If WAIT_CYCLES == 1, go to DONE; otherwise go to WAIT.
  - When `req` is low, stay in IDLE.
- **WAIT**
  - Decrement `cnt` each cycle.
  - Go to DONE on the edge where `cnt == 1`.
  - `req` is not sampled in this state.
- **Entry into DONE** (the transition edge)
  - Store: the array word is written with the latched `wdata`.
  - Load: `rdata` is loaded from the array word.
- **DONE**
  - Lasts one cycle. `rvalid = 1` for a load only.
  - Always returns to IDLE, even if `req` is still high. The core has not yet advanced, so the held request must not be re-accepted.
- **Outputs**
  - `stall` is combinational: `(IDLE & req) | WAIT`. It is 0 in DONE.
  - `rdata` holds the last completed load value until the next load completes.
  - The word index is `addr[ADDR_W-1:2]`. `addr[1:0]` is ignored, except under the configuration macro.
  - All accesses are full 32-bit words.

## Timing
- **Request cycle.** A request presented in cycle T while in IDLE raises `stall` combinationally in T.
- **Stall window.** `stall` stays high for exactly WAIT_CYCLES cycles (T through T+WAIT_CYCLES-1).
- **Completion.** DONE occurs in cycle T+WAIT_CYCLES.
  - Loads: `rdata` and `rvalid` are valid in that cycle.
  - Stores: the write is visible to a load accepted in T+WAIT_CYCLES+1.
- **Back-to-back requests.** A new request is accepted no earlier than T+WAIT_CYCLES+1. The minimum request spacing is therefore WAIT_CYCLES+1 cycles.
- **Reset values** (at the edge where `reset` is high):
  - state = IDLE, `cnt` = 0, `rdata` = 0, `rvalid` = 0, `err` = 0.
  - `stall` is forced to 0 while `reset` is high.
  - Array contents are not reset.
- **Reset mid-operation.** The pending access is aborted.
  - A store still in WAIT is dropped.
  - A store whose DONE-entry edge coincides with reset is also dropped; reset has priority.

## Configuration
- **With `DMEM_MISALIGN_CHECK_EN` defined:**
  - A request accepted with `addr[1:0] != 0` performs no array access.
  - It still takes the normal WAIT_CYCLES stall sequence.
  - In DONE it asserts `err = 1` for one cycle, leaves `rvalid = 0` and leaves `rdata` unchanged.
- **Without the macro:**
  - `err` is constant 0.
  - `addr[1:0]` is ignored; accesses are word-aligned by truncation.

## Test plan
- **Store then load.** WAIT_CYCLES=2: store `wdata=0xDEADBEEF` to `addr=0x010`, then load `0x010`.
  - Required: `stall` is high for 2 cycles on each access.
  - Required: on the load's DONE cycle, `rdata=0xDEADBEEF` and `rvalid=1` for exactly one cycle.
- **Held request.** Keep MemRead high across DONE and the following cycle.
  - Required: exactly one access; `stall` rises again only in the cycle after DONE, as a new accept.
- **Simultaneous read and write.** Assert MemRead=MemWrite=1 with `addr=0x004`, `wdata=0x12345678`.
  - Required: a store occurs and `rvalid` stays 0.
  - Required: a later load of `0x004` returns `0x12345678`.
- **Reset during a store.** Assert `reset` during WAIT of a store of `0xA5A5A5A5` to `0x020`, which previously held `0x0`.
  - Required: `stall=0` during reset; state returns to IDLE.
  - Required: a subsequent load returns `0x0`.
- **WAIT_CYCLES=1 build.** Issue a load request.
  - Required: `stall` is high for 1 cycle, then DONE with `rvalid=1`.
  - Required: back-to-back loads are spaced by 2 cycles.
- **Misalignment, macro on.** With `DMEM_MISALIGN_CHECK_EN` defined, load from `addr=0x013`.
  - Required: `err=1` in DONE, `rvalid=0`, `rdata` unchanged.
  - Required: with the macro undefined, the same load returns word `0x010`.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Data-memory responder on the far side of the core's MemRead/MemWrite
// control interface. It accepts one load or store, services it against an
// internal word array after a fixed number of wait states, and freezes the
// pipeline with `stall` while the access is outstanding. Load data returns
// with a one-cycle `rvalid` strobe.
//
// Configuration macro: DMEM_MISALIGN_CHECK_EN
//   defined   : requests with addr[1:0] != 0 skip the array access and pulse
//               `err` in their completion cycle.
//   undefined : addr[1:0] is ignored and `err` is tied to 0.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   MemRead   in   load request
//   MemWrite  in   store request (wins when both strobes are high)
//   addr      in   byte address, word index is addr[ADDR_W-1:2]
//   wdata     in   store data
//   rdata     out  registered load data, holds the last completed load
//   rvalid    out  one-cycle strobe in the load-completion cycle
//   stall     out  combinational pipeline freeze request
//   err       out  misaligned-access strobe (macro builds only)
`timescale 1ns/1ps

module dmem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              stall,
  output logic              err
);

  localparam int         DATA_W   = 32;
  localparam int         IDX_W    = ADDR_W - 2;
  localparam int         DEPTH    = 1 << IDX_W;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req;
  logic       accept;
  logic       stall_c;
  logic       go_done;

  logic              op_wr_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              mis_p0;

  logic              op_wr_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] wdata_c;
  logic              mis_c;
  logic              mis_live;
  logic              do_load;
  logic              do_store;

  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign req = MemRead | MemWrite;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_live = |addr[1:0];
`else
  assign mis_live = 1'b0;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          stall_c = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        // The core has not advanced yet, so a still-high request is stale.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DONE is only ever entered from IDLE or WAIT, never held.
  assign go_done = (state_d == DONE);

  // With WAIT_CYCLES == 1 DONE is entered on the accept edge itself, before
  // the capture registers hold the request, so use the live inputs then.
  assign op_wr_c = (state_q == IDLE) ? MemWrite            : op_wr_p0;
  assign idx_c   = (state_q == IDLE) ? addr[ADDR_W-1:2]    : idx_p0;
  assign wdata_c = (state_q == IDLE) ? wdata               : wdata_p0;
  assign mis_c   = (state_q == IDLE) ? mis_live            : mis_p0;

  assign do_store = go_done &  op_wr_c & ~mis_c;
  assign do_load  = go_done & ~op_wr_c & ~mis_c;

  assign stall = reset ? 1'b0 : stall_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- p0: request capture at accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_p0 <= MemWrite;
      idx_p0   <= addr[ADDR_W-1:2];
      wdata_p0 <= wdata;
      mis_p0   <= mis_live;
    end
  end

  // Reset wins over a store completing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && do_store) mem[idx_c] <= wdata_c;
  end

  // ---- p1: completion outputs, valid during DONE ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= do_load;
      if (do_load) rdata_p1 <= mem[idx_c];
    end
  end

  assign rdata  = rdata_p1;
  assign rvalid = vld_p1;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic err_p1;
  always_ff @(posedge clk) begin
    if (reset) err_p1 <= 1'b0;
    else       err_p1 <= go_done & mis_c;
  end
  assign err = err_p1;
`else
  assign err = 1'b0;
`endif

endmodule
